io_interrupt_bridge: RTL and testbench
======================================

IO_INTERRUPT_BRIDGE -- requirements
Module: io_interrupt_bridge

Interface
REQ-001 Parameter ISR_ADDR, default 8'hF0: program address of the interrupt service routine; the bridge treats a fetch of this address as interrupt acknowledge.
REQ-002 Parameter HOLD_CYCLES, default 8: number of cycles data_in stays stable after acknowledge.
REQ-003 Parameter ACK_TIMEOUT, default 16: number of cycles in WAIT_ACK before the bridge re-raises the interrupt.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-low reset.
REQ-006 Port host_data, input, 8: byte from the external host.
REQ-007 Port host_valid, input, 1: host_data is valid this cycle.
REQ-008 Port host_ready, output, 1: bridge accepts host_data this cycle.
REQ-009 Port data_in, output, 8: byte presented to the processor data input.
REQ-010 Port interrupt, output, 1: interrupt request to the processor.
REQ-011 Port current_address, input, 8: processor program counter.
REQ-012 Port data_out, input, 8: processor output port.
REQ-013 Port out_data, output, 8: captured processor output byte.
REQ-014 Port out_valid, output, 1: single-cycle strobe marking a new out_data value.
REQ-015 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-016 Inbound path: 4-entry FIFO with 2-bit read and write pointers that wrap modulo 4, and a 3-bit count.
- Write: when host_valid and host_ready are both high.
- host_ready = (count < 4).
REQ-017 FIFO full: host_valid while full is not accepted; the FIFO contents and count are unchanged.
REQ-018 A write and a pop in the same cycle leave count unchanged and are both performed.
REQ-019 The FSM has the states IDLE, LOAD, IRQ, WAIT_ACK and HOLD.
REQ-020 IDLE -> LOAD when count > 0.
- The FIFO head is popped into the data_in register on the LOAD edge.
REQ-021 LOAD -> IRQ after one cycle.
- data_in is stable for at least one cycle before interrupt rises.
REQ-022 IRQ: interrupt = 1 for exactly one cycle; then -> WAIT_ACK with the timeout counter cleared.
REQ-023 WAIT_ACK:
- If current_address == ISR_ADDR: -> HOLD with the hold counter cleared.
- Otherwise, when the timeout counter reaches ACK_TIMEOUT-1: -> IRQ (retry), with data_in unchanged.
REQ-024 An acknowledge in the same cycle that the timeout expires takes priority: -> HOLD.
REQ-025 HOLD: data_in is held constant.
- After HOLD_CYCLES cycles -> IDLE.
- The next byte is popped no earlier than the cycle after HOLD exits.
REQ-026 A current_address match outside WAIT_ACK is ignored.
REQ-027 Outside IRQ, interrupt = 0.
REQ-028 data_in changes only on the LOAD edge.
REQ-029 Outbound path: data_out is registered every cycle into a last-value register.
- out_valid = 1 for one cycle when data_out differs from the registered value; on that cycle out_data is loaded with data_out.
- Otherwise out_data holds its value.
REQ-030 The outbound path is independent of the FSM and operates in every state.
REQ-031 The outbound path shall not raise out_valid on the first cycle after reset.

Reset
REQ-032 When reset = 0 at a rising clk edge:
- FSM -> IDLE; FIFO pointers and count = 0; all counters = 0.
- data_in = 8'h00, interrupt = 0, out_data = 8'h00, out_valid = 0, busy = 0.
- host_ready = 0 while reset is asserted.
- The last-value register is loaded with the current data_out.
REQ-033 Reset asserted mid-transaction (any FSM state) aborts the transaction:
- Undelivered FIFO contents and the in-flight byte are discarded.
- interrupt is 0 on the following cycle.

Verification
REQ-034 Single byte:
- Stimulus: push 8'hA5; drive current_address = 8'hF0 three cycles after the interrupt pulse.
- Response: data_in = 8'hA5 one cycle before a 1-cycle interrupt pulse; data_in holds 8'hA5 for 8 cycles after acknowledge; busy then falls.
REQ-035 Full FIFO:
- Stimulus: push 5 bytes, 8'h01..8'h05, back-to-back while the FSM is stalled in WAIT_ACK.
- Response: 8'h01 in flight, 8'h02..8'h05 queued; host_ready = 0 once the FIFO is full; later deliveries occur in order.
REQ-036 Timeout retry:
- Stimulus: never match ISR_ADDR.
- Response: interrupt pulses repeat every 17 cycles (1 IRQ + 16 WAIT_ACK); data_in is unchanged throughout.
REQ-037 Acknowledge and timeout collide:
- Stimulus: current_address = ISR_ADDR on the 16th WAIT_ACK cycle.
- Response: transition to HOLD; no extra interrupt pulse.
REQ-038 Outbound capture:
- Stimulus: data_out sequence 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h7E.
- Response: exactly two out_valid strobes, carrying out_data = 8'h3C and then 8'h7E.
REQ-039 Reset mid-transaction:
- Stimulus: assert reset during HOLD with 2 bytes queued.
- Response: all outputs take their reset values next cycle; no further interrupt pulse after release until a new push.

Source files
------------

// File: rtl/io_interrupt_bridge.sv
// Host-to-processor byte bridge: 4-deep inbound FIFO, interrupt/ack handshake, outbound change capture.
// Ports: clk, reset (sync, active-low), host_data/valid/ready, data_in, interrupt, current_address, data_out, out_data/valid, busy.
module io_interrupt_bridge #(
  parameter logic [7:0] ISR_ADDR    = 8'hF0,
  parameter int         HOLD_CYCLES = 8,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] host_data,
  input  logic       host_valid,
  output logic       host_ready,
  output logic [7:0] data_in,
  output logic       interrupt,
  input  logic [7:0] current_address,
  input  logic [7:0] data_out,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_IRQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  localparam logic [7:0] TO_LAST   = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic [2:0] state;
  logic [7:0] mem [4];
  logic [1:0] wptr;
  logic [1:0] rptr;
  logic [2:0] count;
  logic [7:0] tcnt;
  logic [7:0] hcnt;
  logic [7:0] last;
  logic       push;
  logic       pop;
  logic       ack;

  assign host_ready = reset & ~count[2];
  assign push       = host_valid & host_ready;
  assign pop        = (state == S_IDLE) && (count != 3'd0);
  assign ack        = (current_address == ISR_ADDR);
  assign interrupt  = (state == S_IRQ);
  assign busy       = (state != S_IDLE);

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= host_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      wptr    <= 2'd0;
      rptr    <= 2'd0;
      count   <= 3'd0;
      tcnt    <= 8'd0;
      hcnt    <= 8'd0;
      data_in <= 8'h00;
    end else begin
      if (push) wptr <= wptr + 2'd1;
      if (pop)  rptr <= rptr + 2'd1;
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;

      unique case (state)
        S_IDLE: begin
          if (pop) begin
            data_in <= mem[rptr];
            state   <= S_LOAD;
          end
        end
        S_LOAD: state <= S_IRQ;
        S_IRQ: begin
          tcnt  <= 8'd0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // Acknowledge wins over a coincident timeout.
          if (ack) begin
            hcnt  <= 8'd0;
            state <= S_HOLD;
          end else if (tcnt == TO_LAST) begin
            state <= S_IRQ;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (hcnt == HOLD_LAST) state <= S_IDLE;
          else                   hcnt  <= hcnt + 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Change detector; reset primes last so no strobe follows reset.
  always_ff @(posedge clk) begin
    last <= data_out;
    if (!reset) begin
      out_data  <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (data_out != last);
      if (data_out != last) out_data <= data_out;
    end
  end

endmodule

// File: tb/tb_io_interrupt_bridge.sv
// Directed testbench for io_interrupt_bridge.
// Linear stimulus with immediate-assertion checks and a final summary.
module tb_io_interrupt_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] host_data;
  logic       host_valid;
  logic       host_ready;
  logic [7:0] data_in;
  logic       interrupt;
  logic [7:0] current_address;
  logic [7:0] data_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  io_interrupt_bridge dut (
    .clk             (clk),
    .reset           (reset),
    .host_data       (host_data),
    .host_valid      (host_valid),
    .host_ready      (host_ready),
    .data_in         (data_in),
    .interrupt       (interrupt),
    .current_address (current_address),
    .data_out        (data_out),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until interrupt is seen; returns tick count or -1 on timeout.
  task automatic wait_irq(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (interrupt) begin
        n = i;
        break;
      end
    end
  endtask

  // From LOAD: pulse, ack in WAIT_ACK, hold, then expect next byte.
  task automatic ack_next(input string tag, input logic [7:0] nxt);
    tick();
    check({tag, "_irq"}, interrupt, 1);
    tick();
    current_address = 8'hF0;
    tick();
    current_address = 8'h00;
    repeat (8) tick();
    check({tag, "_idle"}, busy, 0);
    tick();
    check({tag, "_data"}, data_in, nxt);
  endtask

  initial begin
    int n;
    logic ok;
    logic [7:0] dseq [5];
    logic       vexp [5];
    logic [7:0] oexp [5];

    reset = 1'b0;
    host_data = 8'h00;
    host_valid = 1'b0;
    current_address = 8'h00;
    data_out = 8'h00;

    // Reset state
    tick();
    tick();
    check("rst_data_in", data_in, 8'h00);
    check("rst_irq", interrupt, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", host_ready, 0);
    reset = 1'b1;
    #1;
    check("ready_after_rst", host_ready, 1);

    // Single byte
    host_data = 8'hA5;
    host_valid = 1'b1;
    tick();
    host_valid = 1'b0;
    check("sb_idle", busy, 0);
    tick();
    check("sb_load_data", data_in, 8'hA5);
    check("sb_load_noirq", interrupt, 0);
    tick();
    check("sb_irq", interrupt, 1);
    tick();
    check("sb_irq_1cyc", interrupt, 0);
    tick();
    tick();
    current_address = 8'hF0;
    tick();
    current_address = 8'h00;
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (!busy || data_in != 8'hA5 || interrupt) ok = 1'b0;
    end
    check("sb_hold", ok, 1);
    tick();
    check("sb_busy_fall", busy, 0);
    check("sb_data_kept", data_in, 8'hA5);

    // Full FIFO while stalled, then timeout retries
    host_data = 8'h01;
    host_valid = 1'b1;
    tick();
    host_valid = 1'b0;
    tick();
    check("ff_load01", data_in, 8'h01);
    tick();
    check("ff_irq", interrupt, 1);
    tick();
    for (int b = 2; b <= 5; b++) begin
      host_data = 8'(b);
      host_valid = 1'b1;
      tick();
    end
    check("ff_full_ready", host_ready, 0);
    host_data = 8'h06;
    tick();
    host_valid = 1'b0;
    check("ff_still_full", host_ready, 0);
    wait_irq(40, n);
    check("to_first_gap", n, 11);
    check("to_data_kept", data_in, 8'h01);
    wait_irq(40, n);
    check("to_period", n, 17);
    check("to_data_kept2", data_in, 8'h01);

    // Ack on last WAIT_ACK cycle
    tick();
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (interrupt) ok = 1'b0;
    end
    check("col_no_early_irq", ok, 1);
    current_address = 8'hF0;
    tick();
    current_address = 8'h00;
    check("col_no_irq", interrupt, 0);
    check("col_busy", busy, 1);
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (interrupt || !busy || data_in != 8'h01) ok = 1'b0;
    end
    check("col_hold", ok, 1);
    tick();
    check("col_idle", busy, 0);
    check("col_no_early_pop", data_in, 8'h01);
    tick();
    check("ord_02", data_in, 8'h02);
    ack_next("ord_03", 8'h03);
    ack_next("ord_04", 8'h04);
    ack_next("ord_05", 8'h05);
    tick();
    check("ord_05_irq", interrupt, 1);
    tick();
    current_address = 8'hF0;
    tick();
    current_address = 8'h00;
    repeat (8) tick();
    tick();
    check("ord_drained", busy, 0);
    check("ord_no_06", data_in, 8'h05);

    // Outbound capture
    dseq = '{8'h00, 8'h00, 8'h3C, 8'h3C, 8'h7E};
    vexp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    oexp = '{8'h00, 8'h00, 8'h3C, 8'h3C, 8'h7E};
    n = 0;
    for (int i = 0; i < 5; i++) begin
      data_out = dseq[i];
      tick();
      if (out_valid) n++;
      check($sformatf("ob_valid%0d", i), out_valid, vexp[i]);
      check($sformatf("ob_data%0d", i), out_data, oexp[i]);
    end
    tick();
    check("ob_quiet", out_valid, 0);
    check("ob_strobes", n, 2);

    // Reset during HOLD with two bytes queued
    host_data = 8'h11;
    host_valid = 1'b1;
    tick();
    host_data = 8'h22;
    tick();
    host_data = 8'h33;
    tick();
    host_valid = 1'b0;
    check("mr_irq", interrupt, 1);
    tick();
    current_address = 8'hF0;
    tick();
    current_address = 8'h00;
    tick();
    tick();
    check("mr_in_hold", busy, 1);
    check("mr_data", data_in, 8'h11);
    reset = 1'b0;
    data_out = 8'h99;
    #1;
    check("mr_ready_low", host_ready, 0);
    tick();
    check("mr_data_in", data_in, 8'h00);
    check("mr_irq_low", interrupt, 0);
    check("mr_busy", busy, 0);
    check("mr_out_data", out_data, 8'h00);
    check("mr_out_valid", out_valid, 0);
    reset = 1'b1;
    tick();
    check("mr_no_strobe", out_valid, 0);
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (interrupt || busy) ok = 1'b0;
    end
    check("mr_quiet", ok, 1);
    host_data = 8'h44;
    host_valid = 1'b1;
    tick();
    host_valid = 1'b0;
    tick();
    check("mr_new_byte", data_in, 8'h44);
    tick();
    check("mr_new_irq", interrupt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
